// File: rtl/rf_write_arbiter_if.sv
// Bus bundle for the register-file write arbiter: core writeback, load-return stream,
// reg file write port and status.
interface rf_write_arbiter_if #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int FIFO_DEPTH = 4
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic              core_wr_en;
  logic [ADDR_W-1:0] core_rd;
  logic [DATA_W-1:0] core_wdata;
  logic [6:0]        core_opcode;

  logic              ld_valid;
  logic              ld_ready;
  logic [ADDR_W-1:0] ld_rd;
  logic [DATA_W-1:0] ld_wdata;

  logic              rf_en;
  logic [ADDR_W-1:0] rf_rd;
  logic [DATA_W-1:0] rf_wdata;
  logic [6:0]        rf_opcode;

  logic              core_stall;
  logic              init_done;
  logic [CNT_W-1:0]  fifo_count;

  modport slave (
    input  core_wr_en, core_rd, core_wdata, core_opcode,
    input  ld_valid, ld_rd, ld_wdata,
    output ld_ready,
    output rf_en, rf_rd, rf_wdata, rf_opcode,
    output core_stall, init_done, fifo_count
  );

  modport master (
    output core_wr_en, core_rd, core_wdata, core_opcode,
    output ld_valid, ld_rd, ld_wdata,
    input  ld_ready,
    input  rf_en, rf_rd, rf_wdata, rf_opcode,
    input  core_stall, init_done, fifo_count
  );
endinterface

// File: rtl/rf_write_arbiter.sv
// Owns the register-file write port: zero-fills the file after reset, then arbitrates
// between core writeback (priority) and a buffered, squashable load-return stream.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   INIT  | zero-fill x0..x31, one register per cycle; core stalled
//   RUN   | core writeback has priority, FIFO drains on idle cycles
module rf_write_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int FIFO_DEPTH = 4
) (
  input logic             clk,
  input logic             rst_n,
  rf_write_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] INIT_LAST = '1;
  localparam logic [6:0]        OPC_OP    = 7'b0110011;
  localparam logic [6:0]        OPC_LOAD  = 7'b0000011;

  typedef enum logic {INIT, RUN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] init_cnt;

  logic [ADDR_W-1:0]     ent_rd   [FIFO_DEPTH];
  logic [DATA_W-1:0]     ent_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] ent_vld;
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count;

  logic core_take, pop, push, ld_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= INIT;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               init_cnt <= '0;
    else if (state_q == INIT) init_cnt <= init_cnt + ADDR_W'(1);
  end

  always_comb begin
    state_d        = state_q;
    core_take      = 1'b0;
    pop            = 1'b0;
    push           = 1'b0;
    ld_ready       = 1'b0;
    bus.rf_en      = 1'b0;
    bus.rf_rd      = ent_rd[rd_ptr];
    bus.rf_wdata   = ent_data[rd_ptr];
    bus.rf_opcode  = OPC_LOAD;
    bus.core_stall = 1'b1;
    bus.init_done  = 1'b0;
    case (state_q)
      INIT: begin
        bus.rf_en     = 1'b1;
        bus.rf_rd     = init_cnt;
        bus.rf_wdata  = '0;
        bus.rf_opcode = OPC_OP;
        if (init_cnt == INIT_LAST) state_d = RUN;
      end
      RUN: begin
        bus.core_stall = 1'b0;
        bus.init_done  = 1'b1;
        ld_ready       = (count < DEPTH_C);
        // x0 loads complete the handshake but are never queued
        push           = bus.ld_valid && ld_ready && (bus.ld_rd != '0);
        core_take      = bus.core_wr_en && (bus.core_rd != '0);
        if (core_take) begin
          bus.rf_en     = 1'b1;
          bus.rf_rd     = bus.core_rd;
          bus.rf_wdata  = bus.core_wdata;
          bus.rf_opcode = bus.core_opcode;
        end else if (count != '0) begin
          pop       = 1'b1;
          bus.rf_en = ent_vld[rd_ptr];
        end
      end
      default: state_d = INIT;
    endcase
  end

  assign bus.ld_ready   = ld_ready;
  assign bus.fifo_count = count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // A core write kills older queued loads to the same rd; a load pushed in that
  // same cycle is the newer value, so the push below overrides the squash.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_vld <= '0;
    end else begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (core_take && (ent_rd[i] == bus.core_rd)) ent_vld[i] <= 1'b0;
      end
      if (push) ent_vld[wr_ptr] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      ent_rd[wr_ptr]   <= bus.ld_rd;
      ent_data[wr_ptr] <= bus.ld_wdata;
    end
  end
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: expected writes are queued at stimulus time and a
// monitor pops and compares them whenever the arbiter drives rf_en.
module tb_rf_write_arbiter;
  localparam logic [6:0] OPC_OP  = 7'b0110011;
  localparam logic [6:0] OPC_LUI = 7'b0110111;
  localparam logic [6:0] OPC_LD  = 7'b0000011;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic [6:0]  opc;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rf_write_arbiter_if bus ();
  rf_write_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  wr_t exp_q[$];
  int  n_cmp = 0;
  int  n_err = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic expect_wr(input logic [4:0] rd, input logic [31:0] d, input logic [6:0] o);
    wr_t w;
    w.rd = rd; w.data = d; w.opc = o;
    exp_q.push_back(w);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic core(input logic en, input logic [4:0] rd, input logic [31:0] d, input logic [6:0] o);
    bus.core_wr_en = en; bus.core_rd = rd; bus.core_wdata = d; bus.core_opcode = o;
  endtask

  task automatic ld(input logic v, input logic [4:0] rd, input logic [31:0] d);
    bus.ld_valid = v; bus.ld_rd = rd; bus.ld_wdata = d;
  endtask

  // Called just after a rising edge with rst_n low; returns just after the edge entering RUN.
  task automatic run_init();
    for (int i = 0; i < 32; i++) expect_wr(5'(i), 32'h0, OPC_OP);
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      check("init_ld_ready", 64'(bus.ld_ready), 64'd0);
      if (i == 31) check("init_stall", {62'd0, bus.core_stall, bus.init_done}, 64'b10);
    end
    tick();
  endtask

  // Scoreboard monitor
  initial begin
    wr_t w;
    forever begin
      @(negedge clk);
      if (rst_n && bus.rf_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_write: got rd=%0d data=%h opc=%b expected no write",
                   bus.rf_rd, bus.rf_wdata, bus.rf_opcode);
        end else begin
          w = exp_q.pop_front();
          check("rf_write", 64'({bus.rf_rd, bus.rf_wdata, bus.rf_opcode}), 64'(w));
        end
      end
    end
  end

  initial begin
    ld(1'b0, 5'd0, 32'h0);
    core(1'b1, 5'd3, 32'hFFFF, OPC_OP);   // must be ignored during INIT
    repeat (3) @(posedge clk);
    #1;
    check("reset_count", 64'(bus.fifo_count), 64'd0);
    check("reset_status", {61'd0, bus.ld_ready, bus.init_done, bus.core_stall}, 64'b001);

    // T1 zero-fill
    run_init();
    core(1'b0, 5'd0, 32'h0, OPC_OP);
    @(negedge clk);
    check("run_status", {61'd0, bus.ld_ready, bus.init_done, bus.core_stall}, 64'b110);

    // T2 core writes
    tick(); core(1'b1, 5'd5, 32'hDEADBEEF, OPC_LUI); expect_wr(5'd5, 32'hDEADBEEF, OPC_LUI);
    tick(); core(1'b1, 5'd0, 32'h1, OPC_OP);
    @(negedge clk);
    check("x0_core_no_write", 64'(bus.rf_en), 64'd0);
    tick(); core(1'b0, 5'd0, 32'h0, OPC_OP);

    // T3 load on idle port
    ld(1'b1, 5'd7, 32'h12345678); expect_wr(5'd7, 32'h12345678, OPC_LD);
    @(negedge clk);
    check("t3_ld_ready", 64'(bus.ld_ready), 64'd1);
    check("t3_no_bypass", 64'(bus.rf_en), 64'd0);
    tick(); ld(1'b0, 5'd0, 32'h0);
    @(negedge clk);
    check("t3_count_pop", 64'(bus.fifo_count), 64'd1);
    tick();
    @(negedge clk);
    check("t3_count_empty", 64'(bus.fifo_count), 64'd0);

    // T4 fill FIFO behind core writes, then drain with a waiting load
    for (int k = 0; k < 4; k++) begin
      tick();
      core(1'b1, 5'd4, 32'h40 + 32'(k), OPC_OP); expect_wr(5'd4, 32'h40 + 32'(k), OPC_OP);
      ld(1'b1, 5'(10 + k), 32'h100 + 32'(k));
    end
    tick();
    core(1'b1, 5'd4, 32'h44, OPC_OP); expect_wr(5'd4, 32'h44, OPC_OP);
    ld(1'b1, 5'd20, 32'h200);
    @(negedge clk);
    check("t4_full_count", 64'(bus.fifo_count), 64'd4);
    check("t4_full_ready", 64'(bus.ld_ready), 64'd0);
    tick(); core(1'b0, 5'd0, 32'h0, OPC_OP);
    for (int k = 0; k < 4; k++) expect_wr(5'(10 + k), 32'h100 + 32'(k), OPC_LD);
    @(negedge clk);
    check("t4_ready_at_first_pop", 64'(bus.ld_ready), 64'd0);
    tick();
    @(negedge clk);
    check("t4_ready_after_pop", 64'(bus.ld_ready), 64'd1);
    check("t4_count_after_pop", 64'(bus.fifo_count), 64'd3);
    expect_wr(5'd20, 32'h200, OPC_LD);
    tick(); ld(1'b0, 5'd0, 32'h0);
    @(negedge clk);
    check("t4_push_pop_count", 64'(bus.fifo_count), 64'd3);
    repeat (3) tick();
    @(negedge clk);
    check("t4_drained", 64'(bus.fifo_count), 64'd0);

    // T5 squash of an older load by a core write
    tick();
    core(1'b1, 5'd2, 32'h22, OPC_OP); expect_wr(5'd2, 32'h22, OPC_OP);
    ld(1'b1, 5'd9, 32'h1111);
    tick(); ld(1'b0, 5'd0, 32'h0);
    core(1'b1, 5'd9, 32'hAAAA, OPC_OP); expect_wr(5'd9, 32'hAAAA, OPC_OP);
    @(negedge clk);
    check("t5_queued", 64'(bus.fifo_count), 64'd1);
    tick(); core(1'b0, 5'd0, 32'h0, OPC_OP);
    @(negedge clk);
    check("t5_squash_pop", 64'(bus.rf_en), 64'd0);
    check("t5_squash_occupies", 64'(bus.fifo_count), 64'd1);
    tick();
    @(negedge clk);
    check("t5_squash_gone", 64'(bus.fifo_count), 64'd0);

    // Same-cycle core write and load push: load is newer and survives
    tick();
    core(1'b1, 5'd12, 32'hBBBB, OPC_OP); expect_wr(5'd12, 32'hBBBB, OPC_OP);
    ld(1'b1, 5'd12, 32'h3333); expect_wr(5'd12, 32'h3333, OPC_LD);
    tick(); core(1'b0, 5'd0, 32'h0, OPC_OP); ld(1'b0, 5'd0, 32'h0);

    // x0 load is accepted but dropped
    tick(); ld(1'b1, 5'd0, 32'h5555);
    @(negedge clk);
    check("x0_load_ready", 64'(bus.ld_ready), 64'd1);
    tick(); ld(1'b0, 5'd0, 32'h0);
    @(negedge clk);
    check("x0_load_dropped", {63'd0, bus.rf_en}, 64'd0);
    check("x0_load_count", 64'(bus.fifo_count), 64'd0);

    // Core write to x0 lets the FIFO drain
    tick();
    core(1'b1, 5'd14, 32'h66, OPC_OP); expect_wr(5'd14, 32'h66, OPC_OP);
    ld(1'b1, 5'd13, 32'h44);
    tick(); ld(1'b0, 5'd0, 32'h0);
    core(1'b1, 5'd0, 32'h77, OPC_OP); expect_wr(5'd13, 32'h44, OPC_LD);
    tick(); core(1'b0, 5'd0, 32'h0, OPC_OP);

    // T6 reset with two loads queued
    tick();
    core(1'b1, 5'd15, 32'h1, OPC_OP); expect_wr(5'd15, 32'h1, OPC_OP);
    ld(1'b1, 5'd16, 32'hA);
    tick();
    core(1'b1, 5'd15, 32'h2, OPC_OP); expect_wr(5'd15, 32'h2, OPC_OP);
    ld(1'b1, 5'd17, 32'hB);
    tick();
    core(1'b0, 5'd0, 32'h0, OPC_OP); ld(1'b0, 5'd0, 32'h0);
    rst_n = 1'b0;
    #1;
    check("t6_reset_count", 64'(bus.fifo_count), 64'd0);
    check("t6_reset_status", {61'd0, bus.ld_ready, bus.init_done, bus.core_stall}, 64'b001);
    check("t6_reset_rd", 64'(bus.rf_rd), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    run_init();
    @(negedge clk);
    check("t6_rerun_status", {61'd0, bus.ld_ready, bus.init_done, bus.core_stall}, 64'b110);
    check("t6_rerun_count", 64'(bus.fifo_count), 64'd0);

    repeat (3) tick();
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
